switch_router: RTL and testbench

- Registered 2x2 routing crossbar with valid/ready handshakes on every port.
- Each input word carries a destination bit, and the block generates the crossbar setting itself, unlike the plain select-driven swap.
- It sits between two producer lanes (A, B) and two consumer lanes (OUT0, OUT1) in the datapath interconnect.
- It resolves output conflicts with round-robin arbitration and exposes the last routing setting on `sel`.

---
 rtl/switch_router.sv | 126 ++++++++++++
 tb/tb_switch_router.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_router.sv
// -----------------------------------------------------------------------------
// switch_router
//   Registered 2x2 routing crossbar. Each producer lane (A, B) tags its word
//   with a destination bit; the block steers the word to OUT0 or OUT1, holds it
//   in a single output register stage and arbitrates round-robin when both
//   lanes target the same output in the same cycle.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   a_valid/a_data/a_dest    lane A word, payload, destination (0=OUT0, 1=OUT1)
//   a_ready                  lane A accept (combinational)
//   b_valid/b_data/b_dest    lane B word, payload, destination
//   b_ready                  lane B accept (combinational)
//   out0_valid/data/src      OUT0 held word and its source lane (0=A, 1=B)
//   out0_ready               OUT0 consumer accept
//   out1_valid/data/src      OUT1 held word and its source lane
//   out1_ready               OUT1 consumer accept
//   sel                      last crossbar setting (0=straight, 1=crossed)
// -----------------------------------------------------------------------------
module switch_router #(
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [P_WIDTH-1:0] a_data,
  input  logic               a_dest,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [P_WIDTH-1:0] b_data,
  input  logic               b_dest,
  output logic               b_ready,
  output logic               out0_valid,
  output logic [P_WIDTH-1:0] out0_data,
  output logic               out0_src,
  input  logic               out0_ready,
  output logic               out1_valid,
  output logic [P_WIDTH-1:0] out1_data,
  output logic               out1_src,
  input  logic               out1_ready,
  output logic               sel
);

  logic [1:0]         vld_p1;
  logic [1:0]         src_p1;
  logic [P_WIDTH-1:0] data0_p1;
  logic [P_WIDTH-1:0] data1_p1;
  logic               sel_p1;
  logic               prio_p1;   // 0: A favoured on conflict, 1: B favoured

  logic [1:0] can_accept;
  logic [1:0] drain;
  logic [1:0] load_a;
  logic [1:0] load_b;
  logic       conflict;
  logic       a_fire;
  logic       b_fire;

  // An output slot can take a new word if it is empty or is draining this
  // cycle; the latter gives back-to-back throughput.
  assign drain      = vld_p1 & {out1_ready, out0_ready};
  assign can_accept = ~vld_p1 | {out1_ready, out0_ready};

  assign conflict = a_valid & b_valid & (a_dest == b_dest);

  // Ready never looks at the lane's own valid, only at the competing lane.
  assign a_ready = can_accept[a_dest] & ~(b_valid & (b_dest == a_dest) &  prio_p1);
  assign b_ready = can_accept[b_dest] & ~(a_valid & (a_dest == b_dest) & ~prio_p1);

  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;

  // Arbitration guarantees load_a and load_b never hit the same output.
  always_comb begin
    load_a = 2'b00;
    load_b = 2'b00;
    if (a_fire) load_a[a_dest] = 1'b1;
    if (b_fire) load_b[b_dest] = 1'b1;
  end

  // ---- stage p1: output registers, arbitration and crossbar state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 2'b00;
      src_p1   <= 2'b00;
      data0_p1 <= '0;
      data1_p1 <= '0;
      sel_p1   <= 1'b0;
      prio_p1  <= 1'b0;
    end else begin
      vld_p1 <= load_a | load_b | (vld_p1 & ~drain);

      if (load_a[0]) begin
        data0_p1  <= a_data;
        src_p1[0] <= 1'b0;
      end else if (load_b[0]) begin
        data0_p1  <= b_data;
        src_p1[0] <= 1'b1;
      end

      if (load_a[1]) begin
        data1_p1  <= a_data;
        src_p1[1] <= 1'b0;
      end else if (load_b[1]) begin
        data1_p1  <= b_data;
        src_p1[1] <= 1'b1;
      end

      // A granted conflict hands priority to the loser; a blocked one holds.
      if (conflict && can_accept[a_dest]) prio_p1 <= ~prio_p1;

      // Straight when A goes to OUT0 or B goes to OUT1.
      if (a_fire)      sel_p1 <= a_dest;
      else if (b_fire) sel_p1 <= ~b_dest;
    end
  end

  assign out0_valid = vld_p1[0];
  assign out0_data  = data0_p1;
  assign out0_src   = src_p1[0];
  assign out1_valid = vld_p1[1];
  assign out1_data  = data1_p1;
  assign out1_src   = src_p1[1];
  assign sel        = sel_p1;

endmodule

// File: tb/tb_switch_router.sv
// -----------------------------------------------------------------------------
// tb_switch_router
//   Self-checking bench for switch_router: directed scenarios followed by a
//   long randomized run, all compared against a behavioural model of the two
//   output slots plus per-(source, destination) delivery queues.
// -----------------------------------------------------------------------------
module tb_switch_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_dest, a_ready;
  logic [31:0] a_data;
  logic        b_valid, b_dest, b_ready;
  logic [31:0] b_data;
  logic        out0_valid, out0_src, out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid, out1_src, out1_ready;
  logic [31:0] out1_data;
  logic        sel;

  switch_router #(.P_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_dest(a_dest), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_dest(b_dest), .b_ready(b_ready),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_src(out0_src), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_src(out1_src), .out1_ready(out1_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: one slot per output, priority bit, crossbar setting,
  // and a FIFO of accepted-but-not-yet-delivered words per (source, dest).
  logic        m_v   [2];
  logic [31:0] m_d   [2];
  logic        m_src [2];
  logic        m_prio, m_sel;
  logic        m_afire, m_bfire;
  logic [31:0] q [4][$];   // index = src*2 + dest

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_v[n] = 1'b0; m_d[n] = '0; m_src[n] = 1'b0;
    end
    m_prio = 1'b0; m_sel = 1'b0; m_afire = 1'b0; m_bfire = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
  endtask

  function automatic logic [31:0] dut_data(input int n);
    return (n == 0) ? out0_data : out1_data;
  endfunction

  task automatic check_outputs();
    check("out0_valid", out0_valid, m_v[0]);
    check("out1_valid", out1_valid, m_v[1]);
    if (m_v[0]) begin
      check("out0_data", out0_data, m_d[0]);
      check("out0_src",  out0_src,  m_src[0]);
    end
    if (m_v[1]) begin
      check("out1_data", out1_data, m_d[1]);
      check("out1_src",  out1_src,  m_src[1]);
    end
    check("sel", sel, m_sel);
  endtask

  // One clock cycle: check registered outputs, drive inputs, check readies,
  // advance the model, then let the edge happen.
  task automatic step(input logic av, input logic [31:0] ad, input logic adst,
                      input logic bv, input logic [31:0] bd, input logic bdst,
                      input logic r0, input logic r1);
    logic       ca [2];
    logic [1:0] r;
    logic       ea, eb;
    int         idx;
    logic [31:0] w;
    @(negedge clk);
    check_outputs();
    a_valid = av; a_data = ad; a_dest = adst;
    b_valid = bv; b_data = bd; b_dest = bdst;
    out0_ready = r0; out1_ready = r1;
    #1;
    r = {r1, r0};
    for (int n = 0; n < 2; n++) ca[n] = !m_v[n] || r[n];
    ea = ca[adst] && !(bv && (bdst == adst) && m_prio);
    eb = ca[bdst] && !(av && (adst == bdst) && !m_prio);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    m_afire = av && ea;
    m_bfire = bv && eb;
    // Deliveries this edge must match the oldest outstanding word.
    for (int n = 0; n < 2; n++) begin
      if (m_v[n] && r[n]) begin
        idx = int'(m_src[n]) * 2 + n;
        if (q[idx].size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          w = q[idx].pop_front();
          check("sb_order", dut_data(n), w);
        end
        m_v[n] = 1'b0;
      end
    end
    if (av && bv && (adst == bdst) && ca[adst]) m_prio = !m_prio;
    if (m_afire)      m_sel = adst;
    else if (m_bfire) m_sel = !bdst;
    if (m_afire) begin
      m_v[adst] = 1'b1; m_d[adst] = ad; m_src[adst] = 1'b0;
      q[int'(adst)].push_back(ad);
    end
    if (m_bfire) begin
      m_v[bdst] = 1'b1; m_d[bdst] = bd; m_src[bdst] = 1'b1;
      q[2 + int'(bdst)].push_back(bd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r0, input logic r1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, r0, r1);
  endtask

  logic        cav, cadst, cbv, cbdst;
  logic [31:0] cad, cbd;
  logic        saved_prio;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_data = 0; a_dest = 0;
    b_valid = 0; b_data = 0; b_dest = 0;
    out0_ready = 0; out1_ready = 0;
    model_reset();
    #12 rst = 1'b0;

    // Straight then crossed.
    step(1, 32'h11111111, 0, 1, 32'h22222222, 1, 1, 1);
    check("straight_out0", out0_data, 32'h11111111);
    check("straight_out1", out1_data, 32'h22222222);
    check("straight_sel",  sel, 1'b0);
    step(1, 32'h33333333, 1, 1, 32'h44444444, 0, 1, 1);
    check("crossed_out1", out1_data, 32'h33333333);
    check("crossed_out0", out0_data, 32'h44444444);
    check("crossed_sel",  sel, 1'b1);
    idle(1, 1);

    // Round-robin conflict on OUT1: A, B, A, B.
    for (int k = 0; k < 4; k++) begin
      step(1, 32'hA0000000 + k, 1, 1, 32'hB0000000 + k, 1, 1, 1);
      check("rr_src", out1_src, (k % 2 == 1));
      check("rr_out0_empty", out0_valid, 1'b0);
    end
    idle(1, 1);

    // Backpressure on OUT0 only.
    step(1, 32'h55555555, 0, 0, 32'h0, 0, 0, 1);
    step(1, 32'h66666666, 0, 1, 32'h77777777, 1, 0, 1);
    check("bp_a_held", m_afire, 1'b0);
    step(1, 32'h66666666, 0, 0, 32'h0, 0, 1, 1);
    check("bp_refill_valid", out0_valid, 1'b1);
    check("bp_refill_data",  out0_data, 32'h66666666);

    // Blocked conflict: OUT0 full, both lanes target it, priority must hold.
    saved_prio = m_prio;
    for (int k = 0; k < 3; k++) step(1, 32'hC0C0C0C0, 0, 1, 32'hD0D0D0D0, 0, 0, 1);
    step(1, 32'hC0C0C0C0, 0, 1, 32'hD0D0D0D0, 0, 1, 1);
    check("blocked_winner", out0_src, saved_prio);
    idle(1, 1);

    // Asynchronous reset mid-cycle with both outputs full.
    step(1, 32'hE1E1E1E1, 0, 1, 32'hE2E2E2E2, 1, 0, 0);
    a_valid = 0; b_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("rst_out0_valid", out0_valid, 1'b0);
    check("rst_out1_valid", out1_valid, 1'b0);
    check("rst_out0_data",  out0_data, 32'h0);
    check("rst_sel",        sel, 1'b0);
    rst = 1'b0;
    model_reset();
    step(1, 32'hF0F0F0F0, 1, 1, 32'hF1F1F1F1, 1, 1, 1);
    check("rst_first_winner_a", m_afire, 1'b1);
    check("rst_first_src",      out1_src, 1'b0);
    idle(1, 1);

    // Random traffic; producers hold their word until accepted.
    cav = 0; cbv = 0; cad = 0; cbd = 0; cadst = 0; cbdst = 0;
    m_afire = 0; m_bfire = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!(cav && !m_afire)) begin
        cav = ($urandom_range(0, 3) != 0); cad = $urandom; cadst = $urandom_range(0, 1);
      end
      if (!(cbv && !m_bfire)) begin
        cbv = ($urandom_range(0, 3) != 0); cbd = $urandom; cbdst = $urandom_range(0, 1);
      end
      step(cav, cad, cadst, cbv, cbd, cbdst,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    // Let the in-flight words drain; nothing may remain outstanding.
    cav = 0; cbv = 0;
    for (int c = 0; c < 4; c++) idle(1, 1);
    for (int i = 0; i < 4; i++) check("sb_leftover", q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
